// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared op encoding and width defaults for the MAC processing element
package pe_pkg;

  typedef enum logic [1:0] {
    PE_MAC   = 2'd0,
    PE_BIAS  = 2'd1,
    PE_FLUSH = 2'd2,
    PE_RSVD  = 2'd3
  } pe_op_e;

  localparam int PE_DATA_W  = 8;
  localparam int PE_LANES   = 4;
  localparam int PE_ACC_W   = 24;
  localparam int PE_SHIFT_W = 5;

  // Smallest accumulator that holds one full dot product without wrapping.
  function automatic int min_acc_w(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/pe_requant.sv
// rtl/pe_requant.sv - round-half-up arithmetic right shift with saturation to DATA_W
module pe_requant
  import pe_pkg::*;
#(
  parameter int ACC_W   = PE_ACC_W,
  parameter int DATA_W  = PE_DATA_W,
  parameter int SHIFT_W = PE_SHIFT_W
) (
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  data,
  output logic               sat
);

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] r;

  // One extra bit of headroom so the rounding add never overflows.
  always_comb begin
    ext = {acc_in[ACC_W-1], acc_in};
    rnd = '0;
    if (shift != '0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 1'b1);
    end
    r    = (ext + rnd) >>> shift;
    sat  = 1'b0;
    data = r[DATA_W-1:0];
    if (r > SAT_MAX) begin
      data = SAT_MAX[DATA_W-1:0];
      sat  = 1'b1;
    end else if (r < SAT_MIN) begin
      data = SAT_MIN[DATA_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// rtl/pe_mac_lanes.sv - LANES-wide dot-product accumulator with requantized valid/ready output
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int DATA_W  = PE_DATA_W,
  parameter int LANES   = PE_LANES,
  parameter int ACC_W   = PE_ACC_W,
  parameter int SHIFT_W = PE_SHIFT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic                      cmd_last,
  input  logic [LANES*DATA_W-1:0]   x,
  input  logic [LANES*DATA_W-1:0]   w,
  input  logic [SHIFT_W-1:0]        quant_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sat,
  output logic                      illegal_uop
);

  pe_op_e op;
  assign op = pe_op_e'(cmd_op);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic              illegal_q, illegal_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    dot;
  logic [ACC_W-1:0]           acc_sum;
  logic [DATA_W-1:0]          rq_data;
  logic                       rq_sat;
  logic                       accept;

  assign cmd_ready = !out_valid_q || out_ready;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    prod = '0;
    dot  = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = $signed(x[i*DATA_W +: DATA_W]) * $signed(w[i*DATA_W +: DATA_W]);
      dot  = dot + ACC_W'(prod);
    end
  end

  always_comb begin
    acc_sum = acc_q;
    if (op == PE_MAC) begin
      acc_sum = acc_q + dot;
    end else if (op == PE_BIAS) begin
      acc_sum = acc_q + ACC_W'($signed(w[DATA_W-1:0]));
    end
  end

  pe_requant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT_W(SHIFT_W)
  ) u_requant (
    .acc_in(acc_sum),
    .shift (quant_shift),
    .data  (rq_data),
    .sat   (rq_sat)
  );

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    illegal_d   = 1'b0;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      case (op)
        PE_MAC, PE_BIAS: begin
          if (cmd_last) begin
            // Emitting clears acc so the next output window starts fresh.
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
          end else begin
            acc_d = acc_sum;
          end
        end
        PE_FLUSH: acc_d = '0;
        default:  illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sat     = out_sat_q;
  assign illegal_uop = illegal_q;

  assert property (@(posedge clk) ACC_W >= min_acc_w(DATA_W, LANES));

  assert property (@(posedge clk) disable iff (!rst_n)
    (accept && cmd_last && (op == PE_MAC || op == PE_BIAS)) |-> (32'(quant_shift) < ACC_W));

endmodule

// File: tb/tb_pe_mac_lanes.sv
// tb/tb_pe_mac_lanes.sv - randomized and directed checks of pe_mac_lanes against an arithmetic model
module tb_pe_mac_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_last;
  logic [31:0] x;
  logic [31:0] w;
  logic [4:0]  quant_shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        illegal_uop;

  int n_checks = 0;
  int n_errors = 0;

  longint m_acc;
  logic   m_ov;
  longint m_data;
  logic   m_sat;
  logic   m_ill;

  always #5 clk = ~clk;

  pe_mac_lanes #(.DATA_W(8), .LANES(4), .ACC_W(24), .SHIFT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_last(cmd_last), .x(x), .w(w), .quant_shift(quant_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .illegal_uop(illegal_uop)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic longint lane(input logic [31:0] v, input int i);
    logic signed [7:0] b;
    b = v[i*8 +: 8];
    return longint'(b);
  endfunction

  function automatic longint wrap24(input longint v);
    longint t;
    t = v % 16777216;
    if (t < 0) t += 16777216;
    if (t >= 8388608) t -= 16777216;
    return t;
  endfunction

  function automatic void requant(input longint v, input int s, output longint d, output logic sat);
    longint t;
    t = v + ((s > 0) ? (longint'(1) <<< (s - 1)) : 0);
    t = t >>> s;
    sat = 1'b1;
    if (t > 127) d = 127;
    else if (t < -128) d = -128;
    else begin
      d = t;
      sat = 1'b0;
    end
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ov = 0; m_data = 0; m_sat = 0; m_ill = 0;
  endtask

  // Called at a negedge; drives one cycle, checks handshake and registered outputs.
  task automatic step(input logic v, input logic [1:0] op, input logic last,
                      input logic [31:0] xv, input logic [31:0] wv,
                      input logic [4:0] s, input logic rdy);
    logic   acc_ok;
    longint sum;
    cmd_valid = v; cmd_op = op; cmd_last = last; x = xv; w = wv;
    quant_shift = s; out_ready = rdy;
    #1;
    chk("cmd_ready", cmd_ready, !m_ov || rdy);
    acc_ok = v && (!m_ov || rdy);
    m_ill = 1'b0;
    if (m_ov && rdy) m_ov = 1'b0;
    if (acc_ok) begin
      sum = m_acc;
      if (op == 2'd0) sum = wrap24(m_acc + lane(xv,0)*lane(wv,0) + lane(xv,1)*lane(wv,1)
                                         + lane(xv,2)*lane(wv,2) + lane(xv,3)*lane(wv,3));
      if (op == 2'd1) sum = wrap24(m_acc + lane(wv,0));
      if (op == 2'd2) m_acc = 0;
      if (op == 2'd3) m_ill = 1'b1;
      if (op < 2'd2) begin
        if (last) begin
          requant(sum, int'(s), m_data, m_sat);
          m_ov  = 1'b1;
          m_acc = 0;
        end else begin
          m_acc = sum;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", $signed(out_data), m_data);
    chk("out_sat", out_sat, m_sat);
    chk("illegal_uop", illegal_uop, m_ill);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, rdy);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 1'b0);
    chk("rst_illegal", illegal_uop, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rop;
    logic [31:0] rx, rw;
    rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_last = 0; x = 0; w = 0;
    quant_shift = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_valid", out_valid, 1'b0);
    chk("init_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // dot then bias with rounding, then auto-clear
    step(1, 2'd0, 0, pk(1,2,3,4), pk(2,2,2,2), 5'd0, 1);
    step(1, 2'd1, 1, 32'd0, pk(5,0,0,0), 5'd1, 1);
    chk("bias_13", $signed(out_data), 13);
    step(1, 2'd0, 1, pk(1,0,0,0), pk(1,0,0,0), 5'd0, 1);
    chk("auto_clear", $signed(out_data), 1);

    // negative rounding
    step(1, 2'd1, 1, 32'd0, pk(-3,0,0,0), 5'd1, 1);
    chk("neg_rnd_a", $signed(out_data), -1);
    step(1, 2'd1, 1, 32'd0, pk(-4,0,0,0), 5'd2, 1);
    chk("neg_rnd_b", $signed(out_data), -1);

    // saturation both ways
    step(1, 2'd0, 1, pk(127,127,127,127), pk(127,127,127,127), 5'd0, 1);
    chk("sat_pos", $signed(out_data), 127);
    chk("sat_pos_flag", out_sat, 1'b1);
    step(1, 2'd0, 1, pk(-128,-128,-128,-128), pk(127,127,127,127), 5'd0, 1);
    chk("sat_neg", $signed(out_data), -128);
    chk("sat_neg_flag", out_sat, 1'b1);

    // backpressure: stalled MACs must not touch acc
    step(1, 2'd0, 1, pk(1,0,0,0), pk(3,0,0,0), 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'd0, 0, pk(9,9,9,9), pk(9,9,9,9), 5'd0, 0);
      chk("stall_data", $signed(out_data), 3);
      chk("stall_ready", cmd_ready, 1'b0);
    end
    step(1, 2'd0, 1, pk(2,0,0,0), pk(2,0,0,0), 5'd0, 1);
    chk("reload_data", $signed(out_data), 4);
    chk("reload_valid", out_valid, 1'b1);
    idle(1);
    chk("drain_valid", out_valid, 1'b0);

    // reserved op keeps acc
    step(1, 2'd0, 0, pk(1,2,3,4), pk(2,2,2,2), 5'd0, 1);
    step(1, 2'd3, 1, pk(5,5,5,5), pk(5,5,5,5), 5'd0, 1);
    chk("rsvd_pulse", illegal_uop, 1'b1);
    idle(1);
    chk("rsvd_one_cycle", illegal_uop, 1'b0);
    step(1, 2'd1, 1, 32'd0, 32'd0, 5'd0, 1);
    chk("rsvd_acc_kept", $signed(out_data), 20);

    // flush with last emits nothing
    step(1, 2'd0, 0, pk(1,2,3,4), pk(2,2,2,2), 5'd0, 1);
    step(1, 2'd2, 1, 32'd0, 32'd0, 5'd0, 1);
    chk("flush_no_emit", out_valid, 1'b0);
    step(1, 2'd1, 1, 32'd0, pk(7,0,0,0), 5'd0, 1);
    chk("flush_bias_7", $signed(out_data), 7);

    // reset while output pending, and with acc non-zero
    do_reset();
    chk("rst_mid_valid", out_valid, 1'b0);
    step(1, 2'd0, 0, pk(1,2,3,4), pk(2,2,2,2), 5'd0, 1);
    do_reset();
    step(1, 2'd0, 1, pk(1,0,0,0), pk(1,0,0,0), 5'd0, 1);
    chk("rst_acc_gone", $signed(out_data), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rop = 2'($urandom_range(0, 9) < 5 ? 0 : $urandom_range(1, 3));
      rx = $urandom;
      rw = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        rx = pk(127,127,127,127);
        rw = ($urandom_range(0, 1) == 0) ? pk(127,127,127,127) : pk(-128,-128,-128,-128);
      end
      step(1'($urandom_range(0, 3) != 0), rop, 1'($urandom_range(0, 3) == 0), rx, rw,
           5'($urandom_range(0, 23)), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
